// File: rtl/decoding_block.sv
// Receive-side lane decoder: checks 64b/66b and 128b/132b sync headers, buffers payloads
// (active + pending per lane) and replays them one byte per clock; Gen2 bytes pass straight through.
module decoding_block (
  input  logic         dec_clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   gen_speed,
  input  logic         sym_valid,
  input  logic [131:0] lane_0_rx_enc,
  input  logic [131:0] lane_1_rx_enc,
  output logic [7:0]   lane_0_rx,
  output logic [7:0]   lane_1_rx,
  output logic         rx_valid,
  output logic         rx_os,
  output logic         sync_err,
  output logic         overflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [1:0] SPD_GEN2 = 2'd0;
  localparam logic [1:0] SPD_GEN4 = 2'd1;
  localparam logic [1:0] SPD_GEN3 = 2'd2;

  state_t         state_r;
  state_t         state_s;
  logic [3:0]     idx_r;

  logic [127:0]   act_pl0_r;
  logic [127:0]   act_pl1_r;
  logic           act_os_r;
  logic           act_cnt16_r;
  logic [127:0]   pend_pl0_r;
  logic [127:0]   pend_pl1_r;
  logic           pend_os_r;
  logic           pend_cnt16_r;
  logic           pend_full_r;

  logic [127:0]   new_pl0_s;
  logic [127:0]   new_pl1_s;
  logic           new_os_s;
  logic           new_cnt16_s;
  logic           hdr_ok_s;
  logic           is_enc_s;
  logic           sym_ok_s;
  logic           sym_bad_s;
  logic           gen2_s;
  logic           last_s;

  logic [7:0]     out_b0_s;
  logic [7:0]     out_b1_s;
  logic           out_valid_s;
  logic           out_os_s;

  // Header classification on lane 0; lane 1 is sliced with the same type and offsets.
  always_comb begin
    hdr_ok_s    = 1'b0;
    new_os_s    = 1'b0;
    new_cnt16_s = 1'b0;
    new_pl0_s   = 128'd0;
    new_pl1_s   = 128'd0;
    case (gen_speed)
      SPD_GEN3: begin
        new_pl0_s = {64'd0, lane_0_rx_enc[65:2]};
        new_pl1_s = {64'd0, lane_1_rx_enc[65:2]};
        case (lane_0_rx_enc[1:0])
          2'b01: begin
            hdr_ok_s = 1'b1;
            new_os_s = 1'b0;
          end
          2'b10: begin
            hdr_ok_s = 1'b1;
            new_os_s = 1'b1;
          end
          default: begin
            hdr_ok_s = 1'b0;
            new_os_s = 1'b0;
          end
        endcase
      end
      SPD_GEN4: begin
        new_cnt16_s = 1'b1;
        if (lane_0_rx_enc[3:0] == 4'b1010) begin
          hdr_ok_s  = 1'b1;
          new_pl0_s = lane_0_rx_enc[131:4];
          new_pl1_s = lane_1_rx_enc[131:4];
        end else if (lane_0_rx_enc[131:128] == 4'b0101) begin
          hdr_ok_s  = 1'b1;
          new_os_s  = 1'b1;
          new_pl0_s = lane_0_rx_enc[127:0];
          new_pl1_s = lane_1_rx_enc[127:0];
        end else begin
          hdr_ok_s  = 1'b0;
        end
      end
      default: begin
        hdr_ok_s = 1'b0;
      end
    endcase
  end

  assign is_enc_s  = (gen_speed == SPD_GEN3) || (gen_speed == SPD_GEN4);
  assign sym_ok_s  = sym_valid && is_enc_s && hdr_ok_s;
  assign sym_bad_s = sym_valid && is_enc_s && !hdr_ok_s;
  assign gen2_s    = sym_valid && (gen_speed == SPD_GEN2);
  assign last_s    = (state_r == DRAIN) && (idx_r == (act_cnt16_r ? 4'd15 : 4'd7));

  // State register.
  always_ff @(posedge dec_clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else if (!enable) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: a drain only ends when nothing is queued or arriving on its last byte.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sym_ok_s) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (last_s && !pend_full_r && !sym_ok_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output selection; an active drain takes the output over a Gen2 pass-through byte.
  always_comb begin
    out_b0_s    = 8'd0;
    out_b1_s    = 8'd0;
    out_valid_s = 1'b0;
    out_os_s    = 1'b0;
    if (state_r == DRAIN) begin
      out_valid_s = 1'b1;
      out_os_s    = act_os_r;
      out_b0_s    = act_pl0_r[{idx_r, 3'b000} +: 8];
      out_b1_s    = act_pl1_r[{idx_r, 3'b000} +: 8];
    end else if (gen2_s) begin
      out_valid_s = 1'b1;
      out_b0_s    = lane_0_rx_enc[7:0];
      out_b1_s    = lane_1_rx_enc[7:0];
    end else begin
      out_valid_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge dec_clk or negedge rst) begin
    if (!rst) begin
      lane_0_rx <= 8'd0;
      lane_1_rx <= 8'd0;
      rx_valid  <= 1'b0;
      rx_os     <= 1'b0;
      sync_err  <= 1'b0;
    end else if (!enable) begin
      lane_0_rx <= 8'd0;
      lane_1_rx <= 8'd0;
      rx_valid  <= 1'b0;
      rx_os     <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      lane_0_rx <= out_b0_s;
      lane_1_rx <= out_b1_s;
      rx_valid  <= out_valid_s;
      rx_os     <= out_os_s;
      sync_err  <= sym_bad_s;
    end
  end

  // Byte index, active/pending buffer and sticky overflow.
  always_ff @(posedge dec_clk or negedge rst) begin
    if (!rst) begin
      idx_r        <= 4'd0;
      act_pl0_r    <= 128'd0;
      act_pl1_r    <= 128'd0;
      act_os_r     <= 1'b0;
      act_cnt16_r  <= 1'b0;
      pend_pl0_r   <= 128'd0;
      pend_pl1_r   <= 128'd0;
      pend_os_r    <= 1'b0;
      pend_cnt16_r <= 1'b0;
      pend_full_r  <= 1'b0;
      overflow     <= 1'b0;
    end else if (!enable) begin
      idx_r        <= 4'd0;
      act_pl0_r    <= 128'd0;
      act_pl1_r    <= 128'd0;
      act_os_r     <= 1'b0;
      act_cnt16_r  <= 1'b0;
      pend_pl0_r   <= 128'd0;
      pend_pl1_r   <= 128'd0;
      pend_os_r    <= 1'b0;
      pend_cnt16_r <= 1'b0;
      pend_full_r  <= 1'b0;
      overflow     <= 1'b0;
    end else if (state_r == IDLE) begin
      idx_r <= 4'd0;
      if (sym_ok_s) begin
        act_pl0_r   <= new_pl0_s;
        act_pl1_r   <= new_pl1_s;
        act_os_r    <= new_os_s;
        act_cnt16_r <= new_cnt16_s;
      end
    end else if (last_s) begin
      idx_r <= 4'd0;
      if (pend_full_r) begin
        // Pending promotes; a symbol arriving now refills pending without loss.
        act_pl0_r   <= pend_pl0_r;
        act_pl1_r   <= pend_pl1_r;
        act_os_r    <= pend_os_r;
        act_cnt16_r <= pend_cnt16_r;
        if (sym_ok_s) begin
          pend_pl0_r   <= new_pl0_s;
          pend_pl1_r   <= new_pl1_s;
          pend_os_r    <= new_os_s;
          pend_cnt16_r <= new_cnt16_s;
        end else begin
          pend_full_r  <= 1'b0;
        end
      end else if (sym_ok_s) begin
        act_pl0_r   <= new_pl0_s;
        act_pl1_r   <= new_pl1_s;
        act_os_r    <= new_os_s;
        act_cnt16_r <= new_cnt16_s;
      end
    end else begin
      idx_r <= idx_r + 4'd1;
      if (sym_ok_s) begin
        if (!pend_full_r) begin
          pend_pl0_r   <= new_pl0_s;
          pend_pl1_r   <= new_pl1_s;
          pend_os_r    <= new_os_s;
          pend_cnt16_r <= new_cnt16_s;
          pend_full_r  <= 1'b1;
        end else begin
          overflow     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/decoding_block.md
# decoding_block

Receive-side counterpart of the lane encoder. It accepts one encoded symbol per lane from the deserializer and checks the sync header. It then strips the header and replays the payload as a byte stream on both lanes, one byte per clock, tagging each byte as data or ordered-set. It sits between the deserializer and the lane-level receive logic and supports 64b/66b (Gen3), 128b/132b (Gen4) and 8-bit pass-through (Gen2).

## Interface
- No parameters.
- dec_clk  in  1  block clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  synchronous clear when low; same effect as reset but applied at the clock edge.
- gen_speed  in  2  0 = Gen2 pass-through, 2 = Gen3 66b, 1 = Gen4 132b, 3 = reserved.
- sym_valid  in  1  one-cycle pulse; the encoded lane symbols are valid this cycle.
- lane_0_rx_enc  in  132  encoded symbol, lane 0; Gen3 uses [65:0].
- lane_1_rx_enc  in  132  encoded symbol, lane 1.
- lane_0_rx  out  8  decoded byte, lane 0.
- lane_1_rx  out  8  decoded byte, lane 1.
- rx_valid  out  1  lane_x_rx hold a valid byte this cycle.
- rx_os  out  1  current byte belongs to an ordered-set symbol.
- sync_err  out  1  one-cycle pulse; the accepted symbol had an invalid header and was dropped.
- overflow  out  1  sticky; a symbol was dropped because the buffer was full. Cleared only by reset or enable low.

## Operation
Header classification uses lane 0 only. Lane 1 is decoded with the same type and offsets.
- Gen3 data: bits [1:0] = 2'b01. Payload is [65:2], and byte k = [2+8k+7 : 2+8k], k = 0..7.
- Gen3 ordered set: bits [1:0] = 2'b10. Payload is laid out the same way as Gen3 data.
- Gen3 error: any other value of bits [1:0].
- Gen4: bits [3:0] are checked first.
  - Bits [3:0] = 4'b1010: data. Payload is [131:4], and byte k = [4+8k+7 : 4+8k], k = 0..15.
  - Else bits [131:128] = 4'b0101: ordered set. Payload is [127:0], and byte k = [8k+7 : 8k].
  - Else: error.
- Gen2: no header. On every sym_valid, lane_x_rx <= lane_x_rx_enc[7:0] and rx_valid = 1 for one cycle. rx_os = 0. No buffering.
- Reserved speed (3): sym_valid is ignored and all outputs stay 0.

Buffer (Gen3/Gen4): two entries per lane, active and pending. Each entry stores the 128-bit payload, an os flag and the byte count (8 or 16). Mode is latched per symbol at load.

State machine: IDLE and DRAIN, with byte index idx of 4 bits.
- IDLE, valid symbol arrives: load it into active, idx = 0, go to DRAIN.
- DRAIN, each cycle: emit active byte idx with rx_valid = 1 and rx_os = active os flag, then increment idx.
- DRAIN, last byte (idx = count-1):
  - If pending is full, move pending to active, idx = 0, stay in DRAIN.
  - Else, if a valid symbol arrives this cycle, load it directly into active, idx = 0, stay in DRAIN.
  - Else, go to IDLE.
- DRAIN, valid symbol arrives but not on the last byte:
  - If pending is empty, load it into pending.
  - If pending is full, drop it and set overflow.
- Last byte, pending full, and a new symbol arrives at the same cycle: pending moves to active and the new symbol goes to pending. No overflow.
- Invalid header: the symbol is not loaded, sync_err pulses and the current drain continues uninterrupted. sync_err has priority over the overflow check, so an invalid symbol never sets overflow.

## Timing
- Reset or enable low: all outputs are 0, the buffer is empty, state is IDLE and idx = 0.
- Latency: sym_valid sampled at edge N produces byte 0 at the output after edge N+1, and the last byte after edge N+count.
- Outputs are registered. rx_valid is 0 on any cycle without a byte.
- Back-to-back symbols with one symbol every count cycles give a gap-free byte stream.
- sync_err asserts after the edge at which the bad symbol was sampled and lasts one cycle.
- Reset mid-drain aborts immediately; no partial bytes follow.
- Gen2: the output appears one cycle after sym_valid.

## Test plan
- Gen3 data: lane_0_rx_enc = {64'h0807060504030201, 2'b01} with sym_valid for 1 cycle -> bytes 01..08 on 8 consecutive cycles, rx_os = 0, then rx_valid = 0.
- Gen4 ordered set: lane_0_rx_enc = {4'b0101, 128'h0F0E..0100} -> bytes 00..0F over 16 cycles with rx_os = 1. Repeat with header 4'b1010 in [3:0] -> rx_os = 0, payload taken from [131:4].
- Bad header: Gen3 symbol with [1:0] = 2'b11 -> sync_err = 1 for 1 cycle, no rx_valid, overflow stays 0.
- Back-to-back Gen3: sym_valid every 8 cycles for 4 symbols -> 32 contiguous valid bytes. Then send 3 symbols within one drain -> overflow = 1 and the third symbol is absent from the output.
- Gen2: lane_1_rx_enc[7:0] = 8'hA5 with sym_valid -> lane_1_rx = A5 and rx_valid = 1 for one cycle.
- Reset: assert rst low at byte 3 of a Gen4 drain -> all outputs 0 immediately. Resume with a new symbol after reset release -> byte 0 of the new symbol.
